// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s sequencer: FSM state encoding and default sizes.
package p2s_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  // Index width that stays at least one bit wide for degenerate requester counts.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after the last grant wins.
module rr_pick
  import p2s_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_lastGrant,
  output logic            o_valid,
  output logic [IW-1:0]   o_index
);

  int w_dist;
  int w_bestDist;

  // Distance is measured cyclically from last grant + 1, so the nearest active requester wins.
  always_comb begin
    o_valid    = 1'b0;
    o_index    = '0;
    w_dist     = 0;
    w_bestDist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + 2 * NREQ - 1 - int'(i_lastGrant)) % NREQ;
      if (i_req[i] && (w_dist < w_bestDist)) begin
        o_valid    = 1'b1;
        o_index    = IW'(i);
        w_bestDist = w_dist;
      end
    end
  end

endmodule

// File: rtl/p2s_ctrl.sv
// Round-robin sequencer sharing one p2s serial shifter between NREQ requesters.
// Optional watchdog enabled by defining P2S_CTRL_TIMEOUT_EN.
module p2s_ctrl
  import p2s_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  err,
  output logic [WIDTH-1:0]      p2s_data,
  output logic                  p2s_sync,
  input  logic                  p2s_sen
);

  localparam int IW = idxWidth(NREQ);

  state_t           r_state;
  state_t           w_next;
  logic             w_valid;
  logic [IW-1:0]    w_index;
  logic [IW-1:0]    r_winner;
  logic [IW-1:0]    r_lastGrant;
  logic             r_gapCnt;
  logic [WIDTH-1:0] r_p2sData;
  logic             w_wdFire;
  logic             w_ackEn;
  logic [WIDTH-1:0] w_words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign w_words[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req       (req),
    .i_lastGrant (r_lastGrant),
    .o_valid     (w_valid),
    .o_index     (w_index)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    p2s_sync = 1'b0;
    busy     = 1'b1;
    ack      = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_valid) w_next = ST_SYNC;
      end
      ST_SYNC: begin
        p2s_sync = 1'b1;
        if (!p2s_sen)     w_next = ST_SHIFT;
        else if (w_wdFire) w_next = ST_DONE;
      end
      ST_SHIFT: begin
        p2s_sync = 1'b1;
        if (p2s_sen || w_wdFire) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_ackEn) ack = NREQ'(1) << r_winner;
        w_next = ST_GAP;
      end
      ST_GAP: begin
        if (r_gapCnt) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The shifter word is captured only at grant, so requesters may change req_data afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_p2sData   <= '0;
      r_winner    <= '0;
      r_lastGrant <= IW'(NREQ - 1);
      r_gapCnt    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_valid) begin
        r_p2sData <= w_words[w_index];
        r_winner  <= w_index;
      end
      if (r_state == ST_DONE) r_lastGrant <= r_winner;
      r_gapCnt <= (r_state == ST_GAP) ? ~r_gapCnt : 1'b0;
    end
  end

  assign p2s_data = r_p2sData;

`ifdef P2S_CTRL_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [WDW-1:0] r_wdCnt;
  logic           r_err;
  logic           r_timedOut;
  logic           w_inFrame;
  logic           w_wdExpire;

  assign w_inFrame  = (r_state == ST_SYNC) || (r_state == ST_SHIFT);
  assign w_wdExpire = w_inFrame && (r_wdCnt == WDW'(TIMEOUT - 1));
  // Fires only when the sen edge expected in the current state has not arrived.
  assign w_wdFire   = w_wdExpire &&
                      (((r_state == ST_SYNC) && p2s_sen) || ((r_state == ST_SHIFT) && !p2s_sen));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdCnt    <= '0;
      r_err      <= 1'b0;
      r_timedOut <= 1'b0;
    end else begin
      r_wdCnt <= w_inFrame ? (r_wdCnt + 1'b1) : '0;
      if (w_wdFire) begin
        r_err      <= 1'b1;
        r_timedOut <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        r_timedOut <= 1'b0;
      end
    end
  end

  assign err     = r_err;
  assign w_ackEn = ~r_timedOut;
`else
  assign w_wdFire = 1'b0;
  assign err      = 1'b0;
  assign w_ackEn  = 1'b1;
`endif

endmodule

// File: tb/tb_p2s_ctrl.sv
// Self-checking bench for p2s_ctrl with a behavioural p2s shifter and a transaction-level arbiter model.
module tb_p2s_ctrl;

   localparam int WIDTH   = 16;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 20;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       ack;
   logic                  busy;
   logic                  err;
   logic [WIDTH-1:0]      p2s_data;
   logic                  p2s_sync;
   logic                  p2s_sen;

   int total = 0;
   int bad   = 0;

   // Reference model state: pending requests, their words, and the last requester served.
   logic [NREQ-1:0]  pend;
   logic [WIDTH-1:0] words [NREQ];
   int               lastG;
   int               expW;
   logic [WIDTH-1:0] expWord;

   logic senStuck;
   logic syncQ1, syncQ2;
   int   shiftLeft;

   p2s_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .busy     (busy),
      .err      (err),
      .p2s_data (p2s_data),
      .p2s_sync (p2s_sync),
      .p2s_sen  (p2s_sen)
   );

   always #5 clk = ~clk;

   // Behavioural shifter: sync seen through two flops, sen low for WIDTH cycles per frame.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         syncQ1    <= 1'b0;
         syncQ2    <= 1'b0;
         p2s_sen   <= 1'b1;
         shiftLeft <= 0;
      end else begin
         syncQ1 <= p2s_sync;
         syncQ2 <= syncQ1;
         if (senStuck) begin
            p2s_sen <= 1'b1;
         end else if (syncQ1 && !syncQ2) begin
            p2s_sen   <= 1'b0;
            shiftLeft <= WIDTH;
         end else if (shiftLeft > 0) begin
            shiftLeft <= shiftLeft - 1;
            if (shiftLeft == 1) p2s_sen <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];
      req = pend;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int rrNext(input logic [NREQ-1:0] p, input int last);
      for (int off = 1; off <= NREQ; off++)
         if (p[(last + off) % NREQ]) return (last + off) % NREQ;
      return -1;
   endfunction

   task automatic doReset(input string tag);
      rstn = 1'b0;
      pend = '0;
      applyStimulus();
      lastG = NREQ - 1;
      #1;
      checkOutput({tag, "_rstSync"}, p2s_sync, 0);
      checkOutput({tag, "_rstAck"},  ack,      0);
      checkOutput({tag, "_rstBusy"}, busy,     0);
      checkOutput({tag, "_rstData"}, p2s_data, 0);
      checkOutput({tag, "_rstErr"},  err,      0);
      repeat (2) step();
      rstn = 1'b1;
      step();
   endtask

   // Called one cycle before the expected grant takes effect.
   task automatic grantCheck(input string tag);
      expW    = rrNext(pend, lastG);
      expWord = (expW >= 0) ? words[expW] : '0;
      step();
      checkOutput({tag, "_grantSync"}, p2s_sync, 1);
      checkOutput({tag, "_grantData"}, p2s_data, expWord);
      checkOutput({tag, "_grantBusy"}, busy,     1);
   endtask

   task automatic waitAck(input string tag, input int startN);
      int n;
      bit seen;
      n    = startN;
      seen = 1'b0;
      while (!seen && n < startN + 4 * WIDTH) begin
         step();
         n++;
         if (ack !== '0) seen = 1'b1;
      end
      if (!seen) begin
         checkOutput({tag, "_ackTimeout"}, 0, 1);
      end else begin
         checkOutput({tag, "_ack"},      ack,      32'(1) << expW);
         checkOutput({tag, "_ackData"},  p2s_data, expWord);
         checkOutput({tag, "_frameLen"}, n,        WIDTH + 3);
         lastG = expW;
      end
   endtask

   // Starts at the ack cycle with pend already updated for the next arbitration.
   task automatic postAck(input string tag);
      for (int k = 1; k <= 3; k++) begin
         step();
         checkOutput({tag, "_gapSync"}, p2s_sync, 0);
         if (k == 1) checkOutput({tag, "_ackPulse"}, ack, 0);
         if (k == 2) checkOutput({tag, "_gapBusy"}, busy, 1);
         if (k == 3) checkOutput({tag, "_idleBusy"}, busy, 0);
      end
      if (pend != '0) grantCheck(tag);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      bit ackSeen;
      senStuck = 1'b0;
      rstn     = 1'b0;
      pend     = '0;
      for (int i = 0; i < NREQ; i++) words[i] = '0;
      applyStimulus();
      lastG = NREQ - 1;

      // Single request from requester 0.
      doReset("single");
      words[0] = 16'hA5C3;
      pend     = 2'b01;
      applyStimulus();
      grantCheck("single");
      waitAck("single", 0);
      pend = '0;
      applyStimulus();
      postAck("single");
      repeat (3) step();
      checkOutput("single_stayIdle", busy, 0);

      // Both requesters held high: grants must alternate.
      doReset("both");
      words[0] = WIDTH'($urandom);
      words[1] = WIDTH'($urandom);
      pend     = 2'b11;
      applyStimulus();
      grantCheck("both");
      for (int f = 0; f < 4; f++) begin
         waitAck("both", 0);
         words[expW] = WIDTH'($urandom);
         applyStimulus();
         postAck("both");
      end

      // Reset in the middle of SHIFT, then both request again.
      repeat (8) step();
      rstn = 1'b0;
      #1;
      checkOutput("midRst_sync", p2s_sync, 0);
      checkOutput("midRst_ack",  ack,      0);
      checkOutput("midRst_busy", busy,     0);
      checkOutput("midRst_data", p2s_data, 0);
      step();
      rstn  = 1'b1;
      lastG = NREQ - 1;
      pend  = 2'b11;
      applyStimulus();
      grantCheck("midRst");
      checkOutput("midRst_firstWinner", expW, 0);
      waitAck("midRst", 0);
      pend = '0;
      applyStimulus();
      postAck("midRst");

      // Requester 1 withdraws during SHIFT; the frame still completes.
      words[1] = 16'h3C5A;
      pend     = 2'b10;
      applyStimulus();
      grantCheck("withdraw");
      repeat (8) step();
      pend = '0;
      applyStimulus();
      waitAck("withdraw", 8);
      postAck("withdraw");
      repeat (5) step();
      checkOutput("withdraw_noRegrantSync", p2s_sync, 0);
      checkOutput("withdraw_noRegrantBusy", busy,     0);

      // Shifter never responds.
      doReset("wd");
      senStuck = 1'b1;
      words[0] = 16'h1234;
      pend     = 2'b01;
      applyStimulus();
      grantCheck("wd");
      ackSeen = 1'b0;
`ifdef P2S_CTRL_TIMEOUT_EN
      for (int n = 1; n <= TIMEOUT + 3; n++) begin
         step();
         if (ack !== '0) ackSeen = 1'b1;
         if (n == TIMEOUT - 1) checkOutput("wd_errEarly", err, 0);
         if (n == TIMEOUT)     checkOutput("wd_errSet",   err, 1);
         if (n == TIMEOUT + 3) checkOutput("wd_idleSync", p2s_sync, 0);
      end
      step();
      checkOutput("wd_regrantSync", p2s_sync, 1);
      checkOutput("wd_regrantData", p2s_data, 16'h1234);
      checkOutput("wd_noAck", ackSeen, 0);
      checkOutput("wd_errSticky", err, 1);
`else
      for (int n = 1; n <= 3 * TIMEOUT; n++) begin
         step();
         if (ack !== '0) ackSeen = 1'b1;
      end
      checkOutput("wd_busyHeld", busy,     1);
      checkOutput("wd_syncHeld", p2s_sync, 1);
      checkOutput("wd_errZero",  err,      0);
      checkOutput("wd_noAck",    ackSeen,  0);
`endif
      senStuck = 1'b0;

      // Randomized traffic against the transaction model.
      doReset("rand");
      for (int f = 0; f < 40; f++) begin
         if (pend == '0) begin
            repeat ($urandom_range(0, 3)) step();
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
            applyStimulus();
            grantCheck("rand");
         end
         waitAck("rand", 0);
         if (expW >= 0) begin
            if ($urandom_range(0, 1) == 0) begin
               pend[expW] = 1'b0;
            end else begin
               words[expW] = WIDTH'($urandom);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (i != expW && !pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]  = 1'b1;
               words[i] = WIDTH'($urandom);
            end
         end
         applyStimulus();
         postAck("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
